// File: rtl/data_sampling.sv
// data_sampling: UART oversampling bit sampler; DATA_SAMPLING_MAJORITY_EN selects the 3-tick majority vote, else a single mid-bit sample
module data_sampling #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic                  dat_samp_en,
    input  logic                  rx_in,
    output logic                  sampled_bit,
    output logic                  sample_valid
);
    logic [PRESCALE_W-1:0] mid;
    logic                  ok, at_lo, at_mid, at_hi, unused_dbg;
    logic [2:0]            bit_under_tst;
    logic [1:0]            sample_count;

    // prescale below 4 would put M-1 on tick 0 or wrap, so no tick matches
    always_comb begin
        mid    = prescale >> 1;
        ok     = prescale >= PRESCALE_W'(4);
        at_lo  = ok && edge_cnt == mid - PRESCALE_W'(1);
        at_mid = ok && edge_cnt == mid;
        at_hi  = ok && edge_cnt == mid + PRESCALE_W'(1);
    end

    assign unused_dbg = ^bit_under_tst;

`ifdef DATA_SAMPLING_MAJORITY_EN
    logic vote;
    assign vote = (bit_under_tst[1] & bit_under_tst[0]) | (rx_in & (bit_under_tst[1] | bit_under_tst[0]));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sampled_bit   <= 1'b1;
            sample_valid  <= 1'b0;
            bit_under_tst <= 3'b111;
            sample_count  <= 2'd0;
        end else if (!dat_samp_en || edge_cnt == '0) begin
            sample_valid  <= 1'b0;
            bit_under_tst <= 3'b111;
            sample_count  <= 2'd0;
        end else begin
            sample_valid <= 1'b0;
            if (at_lo || at_mid) begin
                bit_under_tst <= {bit_under_tst[1:0], rx_in};
                sample_count  <= sample_count + 2'd1;
            end
            if (at_hi)
                sample_count <= 2'd0;
`ifdef DATA_SAMPLING_MAJORITY_EN
            if (at_hi) begin
                sampled_bit  <= vote;
                sample_valid <= 1'b1;
            end
`else
            if (at_mid) begin
                sampled_bit  <= rx_in;
                sample_valid <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_data_sampling.sv
// tb_data_sampling: table vectors, hand corner sequences and random bits against a per-bit sample-list model
module tb_data_sampling;
    localparam int W = 6;
`ifdef DATA_SAMPLING_MAJORITY_EN
    localparam bit MAJ = 1'b1;
`else
    localparam bit MAJ = 1'b0;
`endif

    typedef struct {
        int ec;
        bit rx;
        bit eb;
        bit ev;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst, dat_samp_en, rx_in;
    logic [W-1:0] prescale, edge_cnt;
    logic         sampled_bit, sample_valid;

    int compared = 0;
    int mismatched = 0;
    bit m_bit = 1'b1;
    bit m_valid = 1'b0;
    bit q[$];
    int pulses, pulse_tick;
    vec_t vt[8];

    always #5 clk = ~clk;

    data_sampling #(.PRESCALE_W(W)) dut (
        .clk(clk), .rst(rst), .prescale(prescale), .edge_cnt(edge_cnt),
        .dat_samp_en(dat_samp_en), .rx_in(rx_in),
        .sampled_bit(sampled_bit), .sample_valid(sample_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: the samples taken for the current bit; missing samples read as idle 1
    task automatic model_edge();
        int m, ec, ones;
        bit a, b;
        m  = int'(prescale) / 2;
        ec = int'(edge_cnt);
        m_valid = 1'b0;
        if (rst) begin
            m_bit = 1'b1;
            q.delete();
        end else if (!dat_samp_en || ec == 0) begin
            q.delete();
        end else if (prescale >= 4 && (ec == m - 1 || ec == m)) begin
            if (!MAJ && ec == m) begin
                m_bit = rx_in;
                m_valid = 1'b1;
            end
            q.push_back(rx_in);
        end else if (prescale >= 4 && ec == m + 1) begin
            a = q.size() >= 2 ? q[q.size()-2] : 1'b1;
            b = q.size() >= 1 ? q[q.size()-1] : 1'b1;
            if (MAJ) begin
                ones = int'(a) + int'(b) + int'(rx_in);
                m_bit = ones >= 2;
                m_valid = 1'b1;
            end
            q.delete();
        end
    endtask

    task automatic drive(input bit e, input int ec, input bit r);
        dat_samp_en = e;
        edge_cnt = W'(ec);
        rx_in = r;
        @(posedge clk);
        model_edge();
        #1;
        if (sample_valid === 1'b1) begin
            pulses++;
            pulse_tick = ec;
        end
    endtask

    task automatic tick(input string name, input bit e, input int ec, input bit r);
        drive(e, ec, r);
        check($sformatf("%s t%0d bit", name, ec), 32'(sampled_bit), 32'(m_bit));
        check($sformatf("%s t%0d valid", name, ec), 32'(sample_valid), 32'(m_valid));
    endtask

    initial begin
        vt[0] = '{1, 1'b1, 1'b1, 1'b0};
        vt[1] = '{2, 1'b1, 1'b1, 1'b0};
        vt[2] = '{3, 1'b1, 1'b1, 1'b0};
        vt[3] = '{4, 1'b0, MAJ,  !MAJ};
        vt[4] = '{5, 1'b0, 1'b0, MAJ};
        vt[5] = '{6, 1'b0, 1'b0, 1'b0};
        vt[6] = '{7, 1'b0, 1'b0, 1'b0};
        vt[7] = '{0, 1'b0, 1'b0, 1'b0};

        // reset held over an enabled M+1 tick with rx low must still win
        rst = 1'b1;
        prescale = W'(8);
        drive(1'b1, 5, 1'b0);
        drive(1'b1, 5, 1'b0);
        check("reset bit", 32'(sampled_bit), 32'd1);
        check("reset valid", 32'(sample_valid), 32'd0);
        check("reset count", 32'(dut.sample_count), 32'd0);
        check("reset shreg", 32'(dut.bit_under_tst), 32'd7);
        rst = 1'b0;
        drive(1'b1, 0, 1'b1);

        foreach (vt[i]) begin
            drive(1'b1, vt[i].ec, vt[i].rx);
            check($sformatf("table t%0d bit", vt[i].ec), 32'(sampled_bit), 32'(vt[i].eb));
            check($sformatf("table t%0d valid", vt[i].ec), 32'(sample_valid), 32'(vt[i].ev));
        end

        // single-tick glitch at mid-bit
        pulses = 0;
        for (int t = 1; t < 8; t++) tick("glitch", 1'b1, t, t != 4);
        check("glitch result", 32'(sampled_bit), MAJ ? 32'd1 : 32'd0);
        check("glitch pulses", 32'(pulses), 32'd1);
        tick("glitch", 1'b1, 0, 1'b1);

        // prescale 16: two back-to-back bits, no dead cycle at the wrap
        prescale = W'(16);
        for (int b = 0; b < 2; b++) begin
            pulses = 0;
            for (int t = 0; t < 16; t++) tick($sformatf("p16 b%0d", b), 1'b1, t, b == 1);
            check($sformatf("p16 b%0d result", b), 32'(sampled_bit), 32'(b));
            check($sformatf("p16 b%0d pulses", b), 32'(pulses), 32'd1);
            check($sformatf("p16 b%0d pulse tick", b), 32'(pulse_tick), MAJ ? 32'd9 : 32'd8);
        end

        // enable dropped at tick 4
        prescale = W'(8);
        pulses = 0;
        for (int t = 0; t < 8; t++) tick("en drop", t < 4, t, 1'b0);
        check("en drop pulses", 32'(pulses), 32'd0);
        check("en drop bit held", 32'(sampled_bit), 32'd1);
        check("en drop count", 32'(dut.sample_count), 32'd0);

        // reset mid-bit discards the low samples already taken
        for (int t = 0; t < 4; t++) tick("mid rst", 1'b1, t, 1'b0);
        rst = 1'b1;
        tick("mid rst", 1'b1, 4, 1'b0);
        check("mid rst shreg", 32'(dut.bit_under_tst), 32'd7);
        rst = 1'b0;
        for (int t = 5; t < 8; t++) tick("mid rst", 1'b1, t, 1'b0);

        // unsupported prescale: never pulses
        pulses = 0;
        for (int p = 2; p < 4; p++) begin
            prescale = W'(p);
            for (int r = 0; r < 6; r++) tick("bad prescale", 1'b1, r % p, 1'($urandom_range(0, 1)));
        end
        check("bad prescale pulses", 32'(pulses), 32'd0);

        // random bits with glitches and occasional enable drops
        for (int n = 0; n < 60; n++) begin
            int p, dt;
            bit v, drop;
            case ($urandom_range(0, 5))
                0, 1:    p = 8;
                2, 3:    p = 16;
                4:       p = 32;
                default: p = 2 + $urandom_range(0, 1);
            endcase
            prescale = W'(p);
            v = 1'($urandom_range(0, 1));
            drop = $urandom_range(0, 9) == 0;
            dt = $urandom_range(1, p - 1);
            for (int t = 0; t < p; t++)
                tick("rand", !(drop && t >= dt), t, v ^ ($urandom_range(0, 4) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
